// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t         : serial sequencer state encoding (2'b11 is illegal)
//   full_sub_borrow : borrow-out of a one-bit full subtractor (x - y - bin)
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Borrow out of x - y - bin.
  function automatic logic full_sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor, combinational: d = x - y - bin, bout = borrow out.
// Ports:
//   x, y, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_sub
  import serial_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = full_sub_borrow(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, a, b       : request and operands, sampled only in IDLE
//   busy              : high while in SHIFT or DONE
//   done              : one-cycle strobe when diff/bout/ovf are updated
//   diff, bout, ovf   : result, final borrow (a < b), signed overflow; held until next DONE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;
  logic               a_msb;
  logic               b_msb;

  logic               d_bit;
  logic               b_next;
  logic [WIDTH-1:0]   res_next;

  full_sub u_full_sub (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (b_next)
  );

  // New difference bit enters at the MSB; written as a shift so WIDTH=1 needs no special slice.
  assign res_next = (res_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  // Sequencer and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= b_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Last bit: d_bit is the result MSB, b_next the final borrow.
            diff  <= res_next;
            bout  <= b_next;
            ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 builds).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse and check latency and results.
  task automatic run_op(input bit narrow, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input bit exp_b, input bit exp_o,
                        input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    if (narrow) begin start1 = 1'b1; a1 = a[0:0]; b1 = b[0:0]; end
    else        begin start8 = 1'b1; a8 = a;      b8 = b;      end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start8 = 1'b0;
    a8 = 8'hxx;
    b8 = 8'hxx;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if ((narrow ? done1 : done8) === 1'b1) begin lat = i; break; end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (narrow) begin
      chk({tag, "_diff"}, 32'(diff1), 32'(exp_d));
      chk({tag, "_bout"}, 32'(bout1), 32'(exp_b));
      chk({tag, "_ovf"},  32'(ovf1),  32'(exp_o));
    end else begin
      chk({tag, "_diff"}, 32'(diff8), 32'(exp_d));
      chk({tag, "_bout"}, 32'(bout8), 32'(exp_b));
      chk({tag, "_ovf"},  32'(ovf8),  32'(exp_o));
      chk({tag, "_busy_done"}, 32'(busy8), 32'd1);
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, 32'(narrow ? done1 : done8), 32'd0);
    chk({tag, "_idle"},      32'(narrow ? busy1 : busy8), 32'd0);
  endtask

  logic [7:0] opa [30];
  logic [7:0] opb [30];

  initial begin
    int ndone;
    logic [7:0] ea, eb, ed;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_diff", 32'(diff8), 32'd0);
    chk("reset_bout", 32'(bout8), 32'd0);
    chk("reset_ovf",  32'(ovf8),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic and boundary operand patterns.
    run_op(1'b0, 8'd100, 8'd37,  8'd63,  1'b0, 1'b0, 8, "t1_100_37");
    run_op(1'b0, 8'd5,   8'd9,   8'hFC,  1'b1, 1'b0, 8, "t2_5_9");
    run_op(1'b0, 8'hA5,  8'hA5,  8'h00,  1'b0, 1'b0, 8, "t2_eq");
    run_op(1'b0, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b1, 8, "t3_80_01");
    run_op(1'b0, 8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1, 8, "t3_7F_FF");

    // start held high with fresh operands every cycle; edge 0 is the first acceptance.
    for (int i = 0; i < 30; i++) begin
      opa[i] = 8'(i * 37 + 11);
      opb[i] = 8'(i * 91 + 200);
    end
    ndone = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      start8 = 1'b1;
      a8 = opa[cyc];
      b8 = opb[cyc];
      @(posedge clk);
      #1;
      if (done8 === 1'b1) begin
        ndone++;
        chk("t4_done_phase", 32'(cyc % 10), 32'd8);
        if (cyc >= 8) begin
          ea = opa[cyc - 8];
          eb = opb[cyc - 8];
          ed = ea - eb;
          chk("t4_diff", 32'(diff8), 32'(ed));
          chk("t4_bout", 32'(bout8), 32'(ea < eb));
          chk("t4_ovf",  32'(ovf8),  32'((ea[7] != eb[7]) && (ed[7] != ea[7])));
        end
      end
    end
    chk("t4_done_count", 32'(ndone), 32'd3);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_idle_after", 32'(busy8), 32'd0);

    // Reset on the 4th SHIFT edge discards the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_busy", 32'(busy8), 32'd0);
    chk("t5_done", 32'(done8), 32'd0);
    chk("t5_diff", 32'(diff8), 32'd0);
    chk("t5_bout", 32'(bout8), 32'd0);
    chk("t5_ovf",  32'(ovf8),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done8 === 1'b1) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    run_op(1'b0, 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 8, "t5_fresh");

    // WIDTH=1, exhaustive.
    run_op(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1, "t6_00");
    run_op(1'b1, 8'd0, 8'd1, 8'd1, 1'b1, 1'b1, 1, "t6_01");
    run_op(1'b1, 8'd1, 8'd0, 8'd1, 1'b0, 1'b0, 1, "t6_10");
    run_op(1'b1, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0, 1, "t6_11");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
